spi_ram_bridge: RTL

Parametrised SPI-slave-to-single-port-RAM bridge, the successor of the fixed 8-bit-address/8-bit-data SPI+RAM wrapper. It decodes command frames shifted in on MOSI, maintains independent write and read address pointers, and returns read data on MISO. It generalises address width, data width and memory depth, and adds back-to-back frames within one SS_n assertion plus optional address auto-increment for burst transfers. It sits at chip top-level as the host-visible register/memory port.

---
 rtl/spi_ram_pkg.sv | 24 ++
 rtl/spi_ram_mem.sv | 44 ++++
 rtl/spi_ram_bridge.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared definitions for the SPI-to-RAM bridge.
//   - command encodings carried in the two MSBs of every frame
//   - FSM state enum used by spi_ram_bridge
//   - max() helper used to size the frame payload
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT    = 3'd1,
    EXEC     = 3'd2,
    RD_FETCH = 3'd3,
    RD_SEND  = 3'd4
  } state_t;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: single-port synchronous RAM with registered read and
// address range checking (DEPTH may be smaller than 2**ADDR_W).
// Ports:
//   clk    in   clock
//   we     in   write enable; ignored for out-of-range addresses
//   re     in   read enable; loads rdata on the next edge
//   addr   in   [ADDR_W-1:0] shared read/write address
//   wdata  in   [DATA_W-1:0] write data
//   rdata  out  [DATA_W-1:0] registered read data; zero for out-of-range reads
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic              in_range;

  assign in_range = ({1'b0, addr} < DEPTH_X);

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/spi_ram_bridge.sv
// spi_ram_bridge: SPI slave (clocked by clk) bridging command frames to a
// single-port RAM. Frame = cmd[1:0] then payload[PW-1:0], MSB first,
// FL = 2 + max(ADDR_W, DATA_W) bits. Frames may run back to back while SS_n
// stays low; SS_n high in any non-idle state aborts the current frame.
// Optional feature macro: SPI_RAM_AUTOINC_EN (pointer post-increment after
// WR_DATA / RD_DATA, modulo DEPTH).
// Ports:
//   clk    in   system clock and SPI bit clock
//   rst_n  in   asynchronous active-low reset
//   SS_n   in   slave select, active low
//   MOSI   in   serial data in, sampled on rising clk
//   MISO   out  registered serial data out
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | SS_n high, waiting; the select edge also samples bit 0
// SHIFT    | collecting frame bits until FL have been sampled
// EXEC     | decode frame, update pointer / memory, issue RAM read
// RD_FETCH | RAM data valid; load it into the MISO shifter
// RD_SEND  | shifting DATA_W bits out on MISO
module spi_ram_bridge
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int PW = max(ADDR_W, DATA_W);
  localparam int FL = PW + 2;
  localparam int CW = $clog2(FL + 1);
  localparam logic [CW-1:0]     LAST_BIT = CW'(FL - 1);
  localparam logic [CW-1:0]     LAST_TX  = CW'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] PTR_MAX  = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [FL-1:0]     frame_sh;
  logic [CW-1:0]     bit_cnt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] tx_sh;
  logic [1:0]        cmd;
  logic [PW-1:0]     payload;
  logic              frame_start;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign cmd     = frame_sh[FL-1:FL-2];
  assign payload = frame_sh[PW-1:0];

  // Wraps at DEPTH-1; pointers parked above DEPTH-1 roll over at 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // frame_start marks any edge that samples bit 0 of a new frame: the
  // select edge from IDLE, or the closing edge of EXEC / RD_SEND.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    case (state)
      IDLE: begin
        if (!SS_n) begin
          state_nxt   = SHIFT;
          frame_start = 1'b1;
        end
      end
      SHIFT: begin
        if (SS_n) begin
          state_nxt = IDLE;
        end else if (bit_cnt == LAST_BIT) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        // The frame is complete, so its side effects happen even if
        // SS_n has already risen.
        mem_we = (cmd == CMD_WR_DATA);
        mem_re = (cmd == CMD_RD_DATA);
        if (SS_n) begin
          state_nxt = IDLE;
        end else if (cmd == CMD_RD_DATA) begin
          state_nxt = RD_FETCH;
        end else begin
          state_nxt   = SHIFT;
          frame_start = 1'b1;
        end
      end
      RD_FETCH: begin
        state_nxt = SS_n ? IDLE : RD_SEND;
      end
      RD_SEND: begin
        if (SS_n) begin
          state_nxt = IDLE;
        end else if (bit_cnt == LAST_TX) begin
          state_nxt   = SHIFT;
          frame_start = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bit_cnt counts frame bits in SHIFT and transmitted bits in RD_SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_sh <= '0;
      bit_cnt  <= '0;
    end else if (frame_start) begin
      frame_sh <= {frame_sh[FL-2:0], MOSI};
      bit_cnt  <= CW'(1);
    end else begin
      case (state)
        SHIFT: begin
          if (SS_n) begin
            bit_cnt <= '0;
          end else begin
            frame_sh <= {frame_sh[FL-2:0], MOSI};
            bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
          end
        end
        RD_SEND: bit_cnt <= SS_n ? '0 : bit_cnt + 1'b1;
        default: bit_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (state == EXEC) begin
        case (cmd)
          CMD_WR_ADDR: wr_ptr <= payload[ADDR_W-1:0];
          CMD_RD_ADDR: rd_ptr <= payload[ADDR_W-1:0];
`ifdef SPI_RAM_AUTOINC_EN
          CMD_WR_DATA: wr_ptr <= ptr_inc(wr_ptr);
`endif
          default: ;
        endcase
      end
`ifdef SPI_RAM_AUTOINC_EN
      if (state == RD_FETCH && !SS_n) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
`endif
    end
  end

  // MISO leads with the MSB straight from the RAM output; tx_sh holds the
  // remaining bits pre-shifted so RD_SEND always drives tx_sh MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh <= '0;
      MISO  <= 1'b0;
    end else begin
      case (state)
        RD_FETCH: begin
          if (SS_n) begin
            MISO <= 1'b0;
          end else begin
            MISO  <= mem_rdata[DATA_W-1];
            tx_sh <= mem_rdata << 1;
          end
        end
        RD_SEND: begin
          if (SS_n || bit_cnt == LAST_TX) begin
            MISO <= 1'b0;
          end else begin
            MISO  <= tx_sh[DATA_W-1];
            tx_sh <= tx_sh << 1;
          end
        end
        default: MISO <= 1'b0;
      endcase
    end
  end

  assign mem_addr = mem_we ? wr_ptr : rd_ptr;

  spi_ram_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (payload[DATA_W-1:0]),
    .rdata (mem_rdata)
  );

endmodule
